// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state encoding and address-map constants.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_WORD_BYTES        = 4;
    localparam int unsigned DMEM_DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM: one write or one registered read per enabled cycle.
module data_mem_responder_dmem_array #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // NOTE: the array and its read register carry no reset; contents must survive rst and a reset loop would block RAM inference.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline until a load/store completes.
// Optional DMEM_RANGE_ERR_EN adds an err output and suppresses out-of-range accesses instead of wrapping.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned BASE_ADDR   = DMEM_DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
`ifdef DMEM_RANGE_ERR_EN
    output logic        err,
`endif
    output logic        stall
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_SH = $clog2(DMEM_WORD_BYTES);
    localparam int unsigned CNT_W   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    dmem_state_e       r_state;
    dmem_state_e       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_store;
    logic              r_last_load;

    logic              w_request;
    logic              w_accept;
    logic              w_commit;
    logic              w_ready;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic              w_acc_store;
    logic              w_acc_fault;
    logic [IDX_W-1:0]  w_acc_idx;
    logic [31:0]       w_arr_rdata;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> BYTE_SH);
    endfunction

`ifdef DMEM_RANGE_ERR_EN
    // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned test covers both ends.
    function automatic logic out_of_range(input logic [31:0] a);
        return ((a - BASE_ADDR) >> (BYTE_SH + IDX_W)) != 32'd0;
    endfunction
`endif

    assign w_request = mem_r_en | mem_w_en;

    // With LATENCY==1 the array is accessed on the acceptance edge, so the live inputs are used in IDLE.
    assign w_acc_addr  = (r_state == S_IDLE) ? addr     : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata    : r_wdata;
    assign w_acc_store = (r_state == S_IDLE) ? mem_w_en : r_is_store;
    assign w_acc_idx   = word_idx(w_acc_addr);

`ifdef DMEM_RANGE_ERR_EN
    assign w_acc_fault = out_of_range(w_acc_addr);
`else
    assign w_acc_fault = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_ready      = 1'b0;
        stall        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        stall    = 1'b1;
                        w_accept = 1'b1;
                        if (LATENCY == 1) begin
                            w_next_state = S_DONE;
                            w_commit     = 1'b1;
                        end else begin
                            w_next_state = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    stall = 1'b1;
                    if (r_cnt == '0) begin
                        w_next_state = S_DONE;
                        w_commit     = 1'b1;
                    end
                end
                S_DONE: begin
                    w_ready      = 1'b1;
                    w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_store  <= 1'b0;
            r_last_load <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= CNT_INIT;
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_is_store <= mem_w_en;
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_last_load <= !w_acc_store && !w_acc_fault;
            end
        end
    end

    data_mem_responder_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_en    (w_commit),
        .i_we    (w_acc_store && !w_acc_fault),
        .i_idx   (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Stores and faulting loads complete with zero read data, which then holds until the next completion.
    assign rdata = r_last_load ? w_arr_rdata : 32'd0;
    assign ready = w_ready;

`ifdef DMEM_RANGE_ERR_EN
    assign err = w_ready && out_of_range(r_addr);
`endif

endmodule
